spi_slave_controller: RTL
=========================

# spi_slave_controller

Transaction sequencer for the SPI memory slave. Watches the conditioned chip-select and SCLK edge pulses, counts bits, and drives the mode and shift-enable of the 8-bit shift register, the address-latch write enable, the data-memory write enable and the MISO tri-state enable. It sits between the input conditioners and the datapath (shift register, address latch, data memory, MISO buffer) and decides, per transaction, whether the second byte is shifted in (write) or parallel-loaded and shifted out (read).

## Interface
- No parameters; data width fixed at 8 bits, address 7 bits + 1 R/W bit.
- clk  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset.
- csConditioned  input  1  synchronized chip-select, active low.
- sclkPosedge  input  1  one-clk pulse per SCLK rising edge (from conditioner).
- sclkNegedge  input  1  one-clk pulse per SCLK falling edge.
- rwBit  input  1  shift-register parallelOut[0]; 1 = read, 0 = write.
- srMode  output  2  shift-register mode: 00 HOLD, 01 RIGHT, 10 LEFT, 11 PLOAD.
- srShiftEn  output  1  drives shift-register serialClkposedge enable.
- addrWe  output  1  address latch write enable.
- dmWe  output  1  data memory write enable.
- misoBufe  output  1  MISO tri-state buffer enable.
- busy  output  1  high whenever state is not IDLE.

## Operation
- One clock domain; reset is asynchronous, active-low. resetn low: state IDLE, bit counter 0; outputs srMode=00, srShiftEn=0, addrWe=0, dmWe=0, misoBufe=0, busy=0.
- Outputs are combinational decodes of state (plus edge pulses for srShiftEn); state and 3-bit bit counter are registered.
- States and per-state outputs:
  - IDLE: all deasserted, srMode HOLD. csConditioned=0 → GET_ADDR, counter cleared.
  - GET_ADDR: srMode LEFT, srShiftEn=sclkPosedge. Each sclkPosedge increments counter; pulse with counter==7 → LATCH_ADDR, counter cleared.
  - LATCH_ADDR (1 cycle): addrWe=1, srShiftEn=0. rwBit=1 → READ_WAIT; rwBit=0 → WRITE_GET.
  - READ_WAIT (1 cycle): misoBufe=1, srShiftEn=0 (memory read settles) → READ_LOAD.
  - READ_LOAD (1 cycle): misoBufe=1, srMode PLOAD, srShiftEn=1 → READ_SHIFT.
  - READ_SHIFT: misoBufe=1, srMode LEFT, srShiftEn=sclkNegedge; counts negedge pulses; 8th → DONE.
  - WRITE_GET: srMode LEFT, srShiftEn=sclkPosedge; counts posedge pulses; 8th → WRITE_COMMIT.
  - WRITE_COMMIT (1 cycle): dmWe=1 → DONE.
  - DONE: all deasserted, srMode HOLD; csConditioned=1 → IDLE.
- Abort: csConditioned=1 in any state other than IDLE → IDLE next cycle, counter cleared. Outputs in that cycle still follow current state (WRITE_COMMIT still asserts dmWe for its one cycle); no other write occurs.
- Ignored pulses: sclkNegedge in GET_ADDR/WRITE_GET, sclkPosedge in READ_SHIFT, all pulses in single-cycle states and IDLE/DONE. If both pulses arrive together, only the one relevant to the state is used.
- Extra SCLK edges after DONE have no effect until CS deasserts.

## Timing
- CS fall to GET_ADDR: 1 clk.
- 8th address sclkPosedge at cycle N: shift register holds address byte at N+1; LATCH_ADDR at N+1 (addrWe high), address latched at end of N+1.
- Read: READ_WAIT N+2, PLOAD at N+3, MSB on MISO from N+4; master must allow ≥3 clk between 8th SCLK rise and first SCLK fall of data phase.
- Write: 8th data sclkPosedge at cycle M → WRITE_COMMIT at M+1 (dmWe high one cycle), DONE at M+2.
- dmWe and addrWe are never high for more than one consecutive cycle per transaction.

## Test plan
- Reset mid-GET_ADDR (after 3 bits): resetn low → all outputs 0, busy 0 immediately (async); release, new CS fall starts counting from 0.
- Write 0x5A to address 0x21 (first byte 0x42): addrWe pulses once after 8th posedge; dmWe pulses exactly once one cycle after 16th posedge; shift register holds 0x5A during that pulse.
- Read address 0x21 (first byte 0x43): addrWe once, then misoBufe high, one PLOAD cycle with srShiftEn=1, then srShiftEn only on the next 8 sclkNegedge pulses; misoBufe drops on DONE.
- Abort: CS rises after 5 data bits in WRITE_GET → IDLE next cycle, dmWe never asserted, busy 0.
- Spurious pulses: sclkNegedge pulses during GET_ADDR and a simultaneous posedge+negedge in WRITE_GET → counter advances only on posedge; exactly 8 posedges complete each phase.
- Back-to-back: DONE, CS high one cycle, CS low → new transaction starts cleanly with counter 0.

Source files
------------

// File: rtl/spi_slave_controller.sv
// spi_slave_controller: SPI slave transaction sequencer driving the shift register, address latch, memory write and MISO enable
module spi_slave_controller (
    input  logic       clk,
    input  logic       resetn,
    input  logic       csConditioned,
    input  logic       sclkPosedge,
    input  logic       sclkNegedge,
    input  logic       rwBit,
    output logic [1:0] srMode,
    output logic       srShiftEn,
    output logic       addrWe,
    output logic       dmWe,
    output logic       misoBufe,
    output logic       busy
);
    typedef enum logic [3:0] {
        IDLE, GET_ADDR, LATCH_ADDR, READ_WAIT, READ_LOAD,
        READ_SHIFT, WRITE_GET, WRITE_COMMIT, DONE
    } state_t;

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] PLOAD = 2'b11;

    state_t     state, state_next;
    logic [2:0] count, count_next;
    logic       tick;

    // state and bit counter registers
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end

    // next-state, bit counting and per-state output decode; the counter wraps 7->0 so a finished byte leaves it cleared
    always_comb begin
        state_next = state;
        count_next = count;
        tick       = 1'b0;
        srMode     = HOLD;
        srShiftEn  = 1'b0;
        addrWe     = 1'b0;
        dmWe       = 1'b0;
        misoBufe   = 1'b0;
        busy       = state != IDLE;
        case (state)
            IDLE: if (!csConditioned) begin
                state_next = GET_ADDR;
                count_next = '0;
            end
            GET_ADDR: begin
                srMode    = LEFT;
                srShiftEn = sclkPosedge;
                tick      = sclkPosedge;
                if (sclkPosedge && count == 3'd7) state_next = LATCH_ADDR;
            end
            LATCH_ADDR: begin
                addrWe     = 1'b1;
                state_next = rwBit ? READ_WAIT : WRITE_GET;
            end
            READ_WAIT: begin
                misoBufe   = 1'b1;
                state_next = READ_LOAD;
            end
            READ_LOAD: begin
                misoBufe   = 1'b1;
                srMode     = PLOAD;
                srShiftEn  = 1'b1;
                state_next = READ_SHIFT;
            end
            READ_SHIFT: begin
                misoBufe  = 1'b1;
                srMode    = LEFT;
                srShiftEn = sclkNegedge;
                tick      = sclkNegedge;
                if (sclkNegedge && count == 3'd7) state_next = DONE;
            end
            WRITE_GET: begin
                srMode    = LEFT;
                srShiftEn = sclkPosedge;
                tick      = sclkPosedge;
                if (sclkPosedge && count == 3'd7) state_next = WRITE_COMMIT;
            end
            WRITE_COMMIT: begin
                dmWe       = 1'b1;
                state_next = DONE;
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
        if (tick) count_next = count + 3'd1;
        if (state != IDLE && csConditioned) begin
            state_next = IDLE;
            count_next = '0;
        end
    end
endmodule
